// File: rtl/uart_rsp_framer.sv
// Frames 1- or 2-byte response words as SYNC, LEN, D0, [D1], CHK and hands the
// bytes one at a time to a UART transmitter, pacing on its busy handshake.
module uart_rsp_framer #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          TMO_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_RSP_VALID,
  input  logic [15:0]           i_RSP_DATA,
  input  logic                  i_RSP_LEN2,
  output logic                  o_RSP_READY,
  output logic                  o_TX_Data_Valid,
  output logic [DATA_WIDTH-1:0] o_TX_P_DATA,
  input  logic                  i_TX_busy,
  output logic                  o_frame_done,
  output logic                  o_tmo_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]            idx_reg, idx_next;
  logic [TMO_WIDTH-1:0]  tmo_reg, tmo_next, tmo_inc;
  logic [15:0]           data_reg, data_next;
  logic                  len2_reg, len2_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic [DATA_WIDTH-1:0] tx_data_reg, tx_data_next;
  logic                  done_reg, done_next;
  logic                  tmo_err_reg, tmo_err_next;

  logic [DATA_WIDTH-1:0] sync_b, len_b, d0_b, d1_b, chk_b, cur_byte;
  logic                  is_last;
  logic                  tmo_expired;

  // Byte lanes are built bitwise so DATA_WIDTH wider than 8 zero-extends cleanly.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_lane
      if (gi < 8) begin : g_lo
        assign sync_b[gi] = SYNC_BYTE[gi];
        assign d0_b[gi]   = data_reg[gi];
        assign d1_b[gi]   = data_reg[8+gi];
      end else begin : g_hi
        assign sync_b[gi] = 1'b0;
        assign d0_b[gi]   = 1'b0;
        assign d1_b[gi]   = 1'b0;
      end
      if (gi == 0) begin : g_len0
        assign len_b[gi] = ~len2_reg;
      end else if (gi == 1) begin : g_len1
        assign len_b[gi] = len2_reg;
      end else begin : g_lenx
        assign len_b[gi] = 1'b0;
      end
      assign chk_b[gi] = len_b[gi] ^ d0_b[gi] ^ (d1_b[gi] & len2_reg);
    end
  endgenerate

  // Index counts bytes actually sent: slot 3 is D1 for two-byte frames, CHK otherwise.
  always_comb begin
    cur_byte = sync_b;
    case (idx_reg)
      3'd0:    cur_byte = sync_b;
      3'd1:    cur_byte = len_b;
      3'd2:    cur_byte = d0_b;
      3'd3:    cur_byte = len2_reg ? d1_b : chk_b;
      3'd4:    cur_byte = chk_b;
      default: cur_byte = sync_b;
    endcase
  end

  assign is_last     = (idx_reg == (len2_reg ? 3'd4 : 3'd3));
  assign tmo_inc     = tmo_reg + 1'b1;
  assign tmo_expired = (tmo_inc == {TMO_WIDTH{1'b1}});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_RSP_VALID) state_next = LOAD;
      end
      LOAD: begin
        if (!i_TX_busy) state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (i_TX_busy)        state_next = WAIT_LO;
        else if (tmo_expired) state_next = LOAD;
      end
      WAIT_LO: begin
        if (!i_TX_busy) state_next = is_last ? IDLE : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idx_next      = idx_reg;
    tmo_next      = tmo_reg;
    data_next     = data_reg;
    len2_next     = len2_reg;
    tx_valid_next = 1'b0;
    tx_data_next  = tx_data_reg;
    done_next     = 1'b0;
    tmo_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_RSP_VALID) begin
          data_next = i_RSP_DATA;
          len2_next = i_RSP_LEN2;
          idx_next  = 3'd0;
        end
      end
      LOAD: begin
        if (!i_TX_busy) begin
          tx_valid_next = 1'b1;
          tx_data_next  = cur_byte;
          tmo_next      = '0;
        end
      end
      WAIT_HI: begin
        if (!i_TX_busy) begin
          tmo_next = tmo_inc;
          // Transmitter never acknowledged: the same index is re-sent from LOAD.
          if (tmo_expired) tmo_err_next = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!i_TX_busy) begin
          if (is_last) done_next = 1'b1;
          else         idx_next  = idx_reg + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_reg      <= '0;
      tmo_reg      <= '0;
      data_reg     <= '0;
      len2_reg     <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      done_reg     <= 1'b0;
      tmo_err_reg  <= 1'b0;
    end else begin
      idx_reg      <= idx_next;
      tmo_reg      <= tmo_next;
      data_reg     <= data_next;
      len2_reg     <= len2_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      done_reg     <= done_next;
      tmo_err_reg  <= tmo_err_next;
    end
  end

  assign o_RSP_READY     = (state_reg == IDLE);
  assign o_TX_Data_Valid = tx_valid_reg;
  assign o_TX_P_DATA     = tx_data_reg;
  assign o_frame_done    = done_reg;
  assign o_tmo_err       = tmo_err_reg;

endmodule

// File: doc/uart_rsp_framer.md
UART_RSP_FRAMER -- requirements
Module: uart_rsp_framer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 8, byte width toward UART transmitter.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- TMO_WIDTH, 4, width of busy-rise timeout counter; timeout = 2^TMO_WIDTH-1 cycles.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- i_RSP_VALID  in  1  response word offered.
- i_RSP_DATA  in  16  response payload; D0 = [7:0], D1 = [15:8].
- i_RSP_LEN2  in  1  1: two payload bytes; 0: one byte (D0 only).
- o_RSP_READY  out  1  framer idle, accepts a response this cycle.
- o_TX_Data_Valid  out  1  one-cycle byte strobe to UART transmitter.
- o_TX_P_DATA  out  DATA_WIDTH  byte to UART transmitter, stable until next strobe.
- i_TX_busy  in  1  UART transmitter busy.
- o_frame_done  out  1  one-cycle pulse after last byte's busy falls.
- o_tmo_err  out  1  one-cycle pulse per busy-rise timeout.

Function
REQ-003 Frame SHALL be: SYNC_BYTE, LEN, D0, [D1 only if LEN2], CHK; LEN = 8'h02 if i_RSP_LEN2 else 8'h01.
REQ-004 CHK SHALL be XOR of LEN, D0 and D1 (D1 only when present); SYNC_BYTE excluded.
REQ-005 Accept SHALL occur on a cycle with i_RSP_VALID and o_RSP_READY both high; payload, LEN2 captured into internal registers; inputs ignored otherwise.
REQ-006 o_RSP_READY SHALL be high only in IDLE, combinationally from state.
REQ-007 States SHALL be IDLE, LOAD, WAIT_HI, WAIT_LO.
REQ-008 IDLE -> LOAD on accept; byte index cleared to 0.
REQ-009 LOAD: if i_TX_busy low, drive o_TX_Data_Valid high one cycle with current byte on o_TX_P_DATA, clear timeout counter, -> WAIT_HI; if busy high, hold in LOAD without strobe.
REQ-010 WAIT_HI: on i_TX_busy high -> WAIT_LO; else increment timeout counter; at all-ones -> pulse o_tmo_err, -> LOAD re-sending the same byte.
REQ-011 WAIT_LO: on i_TX_busy low, if byte was CHK -> pulse o_frame_done, -> IDLE; else increment byte index, -> LOAD.
REQ-012 Byte index SHALL skip D1 when LEN2 = 0 (index 0..3 one-byte, 0..4 two-byte).
REQ-013 Minimum spacing between strobes SHALL be 3 cycles (LOAD, WAIT_HI, WAIT_LO); back-to-back frames SHALL have one IDLE cycle between o_frame_done and next accept.
REQ-014 o_TX_P_DATA SHALL be registered and change only on the strobe cycle.
REQ-015 i_RSP_VALID during a frame SHALL not alter the frame in progress.

Reset
REQ-016 RST high SHALL asynchronously force IDLE, byte index 0, timeout counter 0, o_TX_Data_Valid 0, o_TX_P_DATA 0, o_frame_done 0, o_tmo_err 0, captured payload 0; o_RSP_READY 1.
REQ-017 RST mid-frame SHALL abandon the frame; no o_frame_done; first accept after release starts a fresh frame from SYNC_BYTE.

Verification
REQ-018 Two-byte: accept 16'h1234, LEN2=1, busy model high 2..10 cycles after each strobe -> strobes A5, 02, 34, 12, 24; one o_frame_done.
REQ-019 One-byte: accept 16'hFF5A, LEN2=0 -> strobes A5, 01, 5A, 5B; D1 never sent.
REQ-020 Timeout: busy held low after first strobe -> o_tmo_err after 15 cycles, A5 re-strobed; busy then responds -> frame completes normally.
REQ-021 Busy stuck high at accept -> no strobe until busy low; then A5 strobed exactly once.
REQ-022 RST asserted in WAIT_LO of D0 -> all outputs reset values immediately, o_RSP_READY=1; next frame starts with A5.
REQ-023 Back-to-back: i_RSP_VALID held high with 16'h0001/LEN2=0 -> two complete frames, accept only in IDLE, payload not resampled mid-frame.
